// File: rtl/alarm_pkg.sv
// Shared alarm types: FSM state, BCD time record and the time-validity check.
// The watch and display stages import the same struct.
package alarm_pkg;

   typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZE} alarm_state_t;

   typedef struct packed {
      logic [3:0] hourdec;
      logic [3:0] hourone;
      logic [3:0] mindec;
      logic [3:0] minone;
   } bcd_time_t;

   localparam int TIMER_W = 10;

   // A 24-hour BCD time: 00:00 .. 23:59
   function automatic logic bcd_time_valid(input bcd_time_t t);
      logic ok;
      ok = (t.hourdec <= 4'd2) && (t.hourone <= 4'd9) &&
           (t.mindec <= 4'd5) && (t.minone <= 4'd9);
      if (t.hourdec == 4'd2 && t.hourone > 4'd3) begin
         ok = 1'b0;
      end
      return ok;
   endfunction

endpackage

// File: rtl/alarm_match.sv
// Combinational compare of the running time against the stored alarm,
// plus the validity check for a candidate alarm time.
module alarm_match
   import alarm_pkg::*;
(
   input  bcd_time_t now,
   input  bcd_time_t alarm,
   input  bcd_time_t cand,
   output logic      match,
   output logic      set_ok
);

   assign match  = (now == alarm);
   assign set_ok = bcd_time_valid(cand);

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: alarm register, rising-edge match detect and the
// arm/ring/snooze state machine driving the buzzer.
module alarm_ctrl
   import alarm_pkg::*;
#(
   parameter int RING_SEC   = 60,
   parameter int SNOOZE_SEC = 300
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic [3:0] hourdec_now,
   input  logic [3:0] hourone_now,
   input  logic [3:0] mindec_now,
   input  logic [3:0] minone_now,
   input  logic       alarm_on,
   input  logic       set_vld,
   input  logic [3:0] set_hourdec,
   input  logic [3:0] set_hourone,
   input  logic [3:0] set_mindec,
   input  logic [3:0] set_minone,
   input  logic       snooze,
   input  logic       stop,
   output logic [3:0] alarm_hourdec,
   output logic [3:0] alarm_hourone,
   output logic [3:0] alarm_mindec,
   output logic [3:0] alarm_minone,
   output logic       set_err,
   output logic       ringing,
   output logic       buzz,
   output logic       snoozed
);

   localparam logic [TIMER_W-1:0] RING_LIM   = TIMER_W'(RING_SEC);
   localparam logic [TIMER_W-1:0] SNOOZE_LIM = TIMER_W'(SNOOZE_SEC);

   bcd_time_t          now_t;
   bcd_time_t          set_t;
   bcd_time_t          alarm_q;
   alarm_state_t       state;
   alarm_state_t       state_nxt;
   logic [TIMER_W-1:0] timer;
   logic [TIMER_W-1:0] timer_nxt;
   logic [TIMER_W-1:0] timer_inc;
   logic               match;
   logic               match_q;
   logic               match_rise;
   logic               set_ok;
   logic               active;
   logic               buzz_nxt;

   assign now_t = {hourdec_now, hourone_now, mindec_now, minone_now};
   assign set_t = {set_hourdec, set_hourone, set_mindec, set_minone};

   alarm_match u_match (
      .now    (now_t),
      .alarm  (alarm_q),
      .cand   (set_t),
      .match  (match),
      .set_ok (set_ok)
   );

   // Fire only on the first cycle of a match, so stopping inside the
   // matching minute cannot re-trigger the alarm.
   assign match_rise = match & ~match_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         timer <= '0;
      end else begin
         state <= state_nxt;
         timer <= timer_nxt;
      end
   end

   // Transition priority: enable switch, set, stop, snooze, timeouts, match, arm
   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      timer_inc = timer + 1'b1;
      active    = (state == RINGING) || (state == SNOOZE);
      if (!alarm_on) begin
         state_nxt = IDLE;
      end else if (set_vld && active) begin
         state_nxt = ARMED;
      end else if (stop && active) begin
         state_nxt = ARMED;
      end else begin
         unique case (state)
            IDLE:    state_nxt = ARMED;
            ARMED:   if (match_rise) state_nxt = RINGING;
            RINGING: begin
               if (snooze) begin
                  state_nxt = SNOOZE;
               end else if (tick) begin
                  if (timer_inc == RING_LIM) state_nxt = ARMED;
                  else                       timer_nxt = timer_inc;
               end
            end
            SNOOZE: begin
               if (tick) begin
                  if (timer_inc == SNOOZE_LIM) state_nxt = RINGING;
                  else                         timer_nxt = timer_inc;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
      if (state_nxt != state) begin
         timer_nxt = '0;
      end
      buzz_nxt = 1'b0;
      if (state == RINGING && state_nxt == RINGING) begin
         buzz_nxt = buzz ^ tick;
      end
   end

   // Output and alarm-register flops; status outputs follow the next state
   // so they change on the same edge as the FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         alarm_q <= '0;
         match_q <= 1'b1;
         set_err <= 1'b0;
         ringing <= 1'b0;
         snoozed <= 1'b0;
         buzz    <= 1'b0;
      end else begin
         if (set_vld && set_ok) begin
            alarm_q <= set_t;
         end
         match_q <= match;
         set_err <= set_vld & ~set_ok;
         ringing <= (state_nxt == RINGING);
         snoozed <= (state_nxt == SNOOZE);
         buzz    <= buzz_nxt;
      end
   end

   assign alarm_hourdec = alarm_q.hourdec;
   assign alarm_hourone = alarm_q.hourone;
   assign alarm_mindec  = alarm_q.mindec;
   assign alarm_minone  = alarm_q.minone;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: a set-register vector table plus
// hand-written ring, stop, snooze, enable, reset and wrap sequences.
module tb_alarm_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        tick;
   logic        alarm_on;
   logic        set_vld;
   logic        snooze;
   logic        stop;
   logic [15:0] now_v;
   logic [15:0] set_v;
   logic [3:0]  alarm_hourdec;
   logic [3:0]  alarm_hourone;
   logic [3:0]  alarm_mindec;
   logic [3:0]  alarm_minone;
   logic        set_err;
   logic        ringing;
   logic        buzz;
   logic        snoozed;

   always #5 clk = ~clk;

   alarm_ctrl #(.RING_SEC(60), .SNOOZE_SEC(300)) dut (
      .clk           (clk),
      .rst           (rst),
      .tick          (tick),
      .hourdec_now   (now_v[15:12]),
      .hourone_now   (now_v[11:8]),
      .mindec_now    (now_v[7:4]),
      .minone_now    (now_v[3:0]),
      .alarm_on      (alarm_on),
      .set_vld       (set_vld),
      .set_hourdec   (set_v[15:12]),
      .set_hourone   (set_v[11:8]),
      .set_mindec    (set_v[7:4]),
      .set_minone    (set_v[3:0]),
      .snooze        (snooze),
      .stop          (stop),
      .alarm_hourdec (alarm_hourdec),
      .alarm_hourone (alarm_hourone),
      .alarm_mindec  (alarm_mindec),
      .alarm_minone  (alarm_minone),
      .set_err       (set_err),
      .ringing       (ringing),
      .buzz          (buzz),
      .snoozed       (snoozed)
   );

   typedef struct {
      string       name;
      logic [15:0] alarm;
      logic        set_err;
      logic        ringing;
      logic        buzz;
      logic        snoozed;
   } exp_t;

   typedef struct {
      logic [15:0] set;
      logic [15:0] alarm;
      logic        err;
   } vec_t;

   exp_t        sb[$];
   vec_t        vecs[7];
   int          total = 0;
   int          bad   = 0;
   logic [15:0] exp_alarm;

   task automatic expect_out(input string name, input logic r, input logic b,
                             input logic s, input logic e = 1'b0);
      exp_t x;
      x.name    = name;
      x.alarm   = exp_alarm;
      x.set_err = e;
      x.ringing = r;
      x.buzz    = b;
      x.snoozed = s;
      sb.push_back(x);
   endtask

   task automatic check_output();
      exp_t        x;
      logic [15:0] act;
      while (sb.size() > 0) begin
         x   = sb.pop_front();
         act = {alarm_hourdec, alarm_hourone, alarm_mindec, alarm_minone};
         total++;
         if (act !== x.alarm || set_err !== x.set_err || ringing !== x.ringing ||
             buzz !== x.buzz || snoozed !== x.snoozed) begin
            bad++;
            $display("[TB] FAIL %s: got alarm=%h err=%b ring=%b buzz=%b snz=%b, want alarm=%h err=%b ring=%b buzz=%b snz=%b",
                     x.name, act, set_err, ringing, buzz, snoozed,
                     x.alarm, x.set_err, x.ringing, x.buzz, x.snoozed);
         end
      end
   endtask

   // One clock: inputs were set at the previous negedge, outputs sampled at this one
   task automatic step();
      @(posedge clk);
      @(negedge clk);
      check_output();
   endtask

   // A tick cycle followed by an idle cycle; outputs expected stable across both
   task automatic apply_tick(input string name, input logic r, input logic b, input logic s);
      tick = 1'b1;
      expect_out(name, r, b, s);
      step();
      tick = 1'b0;
      expect_out({name, "_gap"}, r, b, s);
      step();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic b;
      vecs[0] = '{set: 16'h2400, alarm: 16'h0000, err: 1'b1};
      vecs[1] = '{set: 16'h1260, alarm: 16'h0000, err: 1'b1};
      vecs[2] = '{set: 16'h2359, alarm: 16'h2359, err: 1'b0};
      vecs[3] = '{set: 16'h0A00, alarm: 16'h2359, err: 1'b1};
      vecs[4] = '{set: 16'h1959, alarm: 16'h1959, err: 1'b0};
      vecs[5] = '{set: 16'h3000, alarm: 16'h1959, err: 1'b1};
      vecs[6] = '{set: 16'h0730, alarm: 16'h0730, err: 1'b0};

      rst = 1'b1; tick = 1'b0; alarm_on = 1'b0; set_vld = 1'b0;
      snooze = 1'b0; stop = 1'b0; now_v = 16'h1200; set_v = '0; exp_alarm = '0;
      @(negedge clk);
      expect_out("reset", 0, 0, 0);
      step();
      rst = 1'b0; alarm_on = 1'b1;
      step();

      // Alarm register: invalid sets hold the digits and pulse set_err
      for (int i = 0; i < 7; i++) begin
         set_v = vecs[i].set; set_vld = 1'b1; exp_alarm = vecs[i].alarm;
         expect_out($sformatf("set%0d", i), 0, 0, 0, vecs[i].err);
         step();
         set_vld = 1'b0;
         expect_out($sformatf("set%0d_clr", i), 0, 0, 0);
         step();
      end

      // Fire at 07:30, ring for exactly 60 ticks, no re-fire afterwards
      now_v = 16'h0729; expect_out("pre_fire", 0, 0, 0); step();
      now_v = 16'h0730; expect_out("fire", 1, 0, 0); step();
      for (int k = 1; k <= 60; k++) begin
         b = (k < 60) && (k % 2 == 1);
         apply_tick($sformatf("ring%0d", k), k < 60, b, 0);
      end
      repeat (3) begin expect_out("no_refire", 0, 0, 0); step(); end

      // Stop with a tick in the same cycle, then 30 more ticks inside the minute
      now_v = 16'h0000; step();
      now_v = 16'h0730; expect_out("fire2", 1, 0, 0); step();
      apply_tick("pre_stop", 1, 1, 0);
      stop = 1'b1; tick = 1'b1; expect_out("stop", 0, 0, 0); step();
      stop = 1'b0; tick = 1'b0;
      for (int k = 0; k < 30; k++) apply_tick("after_stop", 0, 0, 0);

      // Snooze for 300 ticks, re-ring at 07:35, then stop+snooze together
      now_v = 16'h0729; step();
      now_v = 16'h0730; expect_out("fire3", 1, 0, 0); step();
      snooze = 1'b1; tick = 1'b1; expect_out("snooze", 0, 0, 1); step();
      snooze = 1'b0; tick = 1'b0; now_v = 16'h0735;
      for (int k = 1; k <= 300; k++) apply_tick($sformatf("snz%0d", k), k == 300, 0, k < 300);
      apply_tick("rering_buzz", 1, 1, 0);
      stop = 1'b1; snooze = 1'b1; expect_out("stop_and_snooze", 0, 0, 0); step();
      stop = 1'b0; snooze = 1'b0;

      // Dropping the enable switch mid-ring
      now_v = 16'h0729; step();
      now_v = 16'h0730; expect_out("fire4", 1, 0, 0); step();
      apply_tick("pre_off", 1, 1, 0);
      alarm_on = 1'b0; expect_out("alarm_off", 0, 0, 0); step();
      alarm_on = 1'b1; expect_out("rearm", 0, 0, 0); step();

      // Setting the alarm to the current time fires next cycle; a set while ringing re-arms
      now_v = 16'h1234; step();
      set_v = 16'h1234; set_vld = 1'b1; exp_alarm = 16'h1234;
      expect_out("set_eq_now", 0, 0, 0); step();
      set_vld = 1'b0; expect_out("set_eq_fire", 1, 0, 0); step();
      set_v = 16'h2400; set_vld = 1'b1; expect_out("set_in_ring", 0, 0, 0, 1); step();
      set_vld = 1'b0; expect_out("no_refire2", 0, 0, 0); step();

      // Reset mid-snooze, then release with the time already at 00:00
      now_v = 16'h1233; step();
      now_v = 16'h1234; expect_out("fire5", 1, 0, 0); step();
      snooze = 1'b1; expect_out("snooze2", 0, 0, 1); step();
      snooze = 1'b0; rst = 1'b1; exp_alarm = 16'h0000;
      expect_out("rst_mid_snooze", 0, 0, 0); step();
      now_v = 16'h0000; step();
      rst = 1'b0;
      repeat (3) begin expect_out("rst_at_0000", 0, 0, 0); step(); end

      // Midnight wrap fires a 00:00 alarm
      now_v = 16'h2359; expect_out("pre_wrap", 0, 0, 0); step();
      now_v = 16'h0000; expect_out("wrap_fire", 1, 0, 0); step();
      stop = 1'b1; expect_out("wrap_stop", 0, 0, 0); step();
      stop = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
